fp_mul_pipe: RTL and testbench

Parametrised, pipelined minifloat multiplier: the successor to our single-format 8-bit FP multiplier. It accepts one operand pair per cycle over a valid/ready handshake and returns the product 3 cycles later. Exponent and mantissa widths, rounding mode and overflow saturation are selectable. The block sits behind the tt_um top-level pin muxing, with operands loaded from ui_in/uio_in and results driven onto uo_out.

---
 rtl/fp_mul_pipe.sv | 197 +++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - three-stage pipelined minifloat multiplier with valid/ready handshake
module fp_mul_pipe #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         rnd_mode,
    input  logic         sat_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int XW   = EXP_W + 2;

    logic               advance;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_man, b_man;
    logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    logic               s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
    logic signed [XW-1:0] s1_exp_q, s1_exp_d;
    logic [PW-1:0]      s1_prod_q, s1_prod_d;
    logic [3:0]         s1_cls_q, s1_cls_d;
    logic               s1_rnd_q, s1_rnd_d, s1_sat_q, s1_sat_d;

    logic               s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
    logic signed [XW-1:0] s2_exp_q, s2_exp_d;
    logic [MAN_W-1:0]   s2_man_q, s2_man_d;
    logic               s2_inexact_q, s2_inexact_d;
    logic [3:0]         s2_cls_q, s2_cls_d;
    logic               s2_sat_q, s2_sat_d;

    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    logic [PW-1:0]      norm;
    logic               guard, sticky, round_up;
    logic [MAN_W:0]     man_r;
    logic               ovf, unf;
    logic [MAN_W-1:0]   nan_man;
    logic [W-1:0]       res_n;
    logic [3:0]         flg_n;

    // The whole pipeline stalls together; bubbles are never collapsed.
    assign advance  = out_ready | ~out_valid_q;
    assign in_ready = advance;

    assign a_exp  = a[W-2 -: EXP_W];
    assign b_exp  = b[W-2 -: EXP_W];
    assign a_man  = a[MAN_W-1:0];
    assign b_man  = b[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) & ~(|a_man);
    assign b_inf  = (&b_exp) & ~(|b_man);
    assign a_nan  = (&a_exp) & (|a_man);
    assign b_nan  = (&b_exp) & (|b_man);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_prod_d  = s1_prod_q;
        s1_cls_d   = s1_cls_q;
        s1_rnd_d   = s1_rnd_q;
        s1_sat_d   = s1_sat_q;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_sign_d  = a[W-1] ^ b[W-1];
            s1_exp_d   = XW'(a_exp) + XW'(b_exp) - XW'(BIAS);
            s1_prod_d  = PW'({1'b1, a_man}) * PW'({1'b1, b_man});
            // {any NaN, zero*inf, any inf, any zero}; priority resolved in stage 3
            s1_cls_d   = {a_nan | b_nan, (a_zero & b_inf) | (a_inf & b_zero), a_inf | b_inf, a_zero | b_zero};
            s1_rnd_d   = rnd_mode;
            s1_sat_d   = sat_mode;
        end
    end

    always_comb begin
        norm     = s1_prod_q[PW-1] ? s1_prod_q : (s1_prod_q << 1);
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = ~s1_rnd_q & guard & (sticky | norm[MAN_W+1]);
        // A carry out leaves the low bits at zero, so the renormalised mantissa is man_r[MAN_W-1:0].
        man_r    = {1'b0, norm[PW-2 -: MAN_W]} + (MAN_W + 1)'(round_up);

        s2_valid_d   = s2_valid_q;
        s2_sign_d    = s2_sign_q;
        s2_exp_d     = s2_exp_q;
        s2_man_d     = s2_man_q;
        s2_inexact_d = s2_inexact_q;
        s2_cls_d     = s2_cls_q;
        s2_sat_d     = s2_sat_q;
        if (advance) begin
            s2_valid_d   = s1_valid_q;
            s2_sign_d    = s1_sign_q;
            s2_exp_d     = s1_exp_q + XW'(s1_prod_q[PW-1]) + XW'(man_r[MAN_W]);
            s2_man_d     = man_r[MAN_W-1:0];
            s2_inexact_d = guard | sticky;
            s2_cls_d     = s1_cls_q;
            s2_sat_d     = s1_sat_q;
        end
    end

    always_comb begin
        ovf     = ~s2_exp_q[XW-1] && (s2_exp_q[XW-2:0] >= (XW - 1)'(EMAX));
        unf     = s2_exp_q[XW-1] || (s2_exp_q == '0);
        nan_man = '0;
        nan_man[MAN_W-1] = 1'b1;
        res_n   = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_man_q};
        flg_n   = {3'b000, s2_inexact_q};
        if (s2_cls_q[3]) begin
            res_n = {1'b0, {EXP_W{1'b1}}, nan_man};
            flg_n = 4'b0000;
        end else if (s2_cls_q[2]) begin
            res_n = {1'b0, {EXP_W{1'b1}}, nan_man};
            flg_n = 4'b1000;
        end else if (s2_cls_q[1]) begin
            res_n = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_n = 4'b0000;
        end else if (s2_cls_q[0]) begin
            res_n = {s2_sign_q, {(W - 1){1'b0}}};
            flg_n = 4'b0000;
        end else if (ovf) begin
            res_n = s2_sat_q ? {s2_sign_q, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                             : {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_n = 4'b0101;
        end else if (unf) begin
            res_n = {s2_sign_q, {(W - 1){1'b0}}};
            flg_n = 4'b0011;
        end

        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (advance) begin
            out_valid_d = s2_valid_q;
            result_d    = res_n;
            flags_d     = flg_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_prod_q    <= '0;
            s1_cls_q     <= '0;
            s1_rnd_q     <= 1'b0;
            s1_sat_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_exp_q     <= '0;
            s2_man_q     <= '0;
            s2_inexact_q <= 1'b0;
            s2_cls_q     <= '0;
            s2_sat_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_prod_q    <= s1_prod_d;
            s1_cls_q     <= s1_cls_d;
            s1_rnd_q     <= s1_rnd_d;
            s1_sat_q     <= s1_sat_d;
            s2_valid_q   <= s2_valid_d;
            s2_sign_q    <= s2_sign_d;
            s2_exp_q     <= s2_exp_d;
            s2_man_q     <= s2_man_d;
            s2_inexact_q <= s2_inexact_d;
            s2_cls_q     <= s2_cls_d;
            s2_sat_q     <= s2_sat_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - self-checking bench for fp_mul_pipe (E4M3 and E5M2 instances)
module tb_fp_mul_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv0, ir0, rm0, sm0, ov0, or0;
    logic [7:0] a0, b0, res0;
    logic [3:0] fl0;
    logic       iv1, ir1, rm1, sm1, ov1, or1;
    logic [7:0] a1, b1, res1;
    logic [3:0] fl1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(4), .MAN_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .rnd_mode(rm0), .sat_mode(sm0), .out_valid(ov0), .out_ready(or0),
        .result(res0), .flags(fl0)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(2)) u_dut_e5m2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .rnd_mode(rm1), .sat_mode(sm1), .out_valid(ov1), .out_ready(or1),
        .result(res1), .flags(fl1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         rnd;
        bit         sat;
        logic [7:0] res;
        logic [3:0] flg;
        bit         e5m2;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: value-level multiply in reals, then rounding and range rules applied to the exact product.
    function automatic logic [11:0] model(input int ew, input int mw, input logic [7:0] x,
                                          input logic [7:0] y, input bit r, input bit s);
        int  bias, emax, xe, xm, ye, ym, sg, e, q, be;
        bit  xz, xi, xn, yz, yi, yn, inx;
        real p, sc, fr;
        logic [7:0] nanv, infv, zerov;
        bias = (1 << (ew - 1)) - 1;
        emax = (1 << ew) - 1;
        xe = (int'(x) >> mw) & emax;
        ye = (int'(y) >> mw) & emax;
        xm = int'(x) & ((1 << mw) - 1);
        ym = int'(y) & ((1 << mw) - 1);
        sg = ((int'(x) ^ int'(y)) >> (ew + mw)) & 1;
        xz = (xe == 0); xi = (xe == emax) && (xm == 0); xn = (xe == emax) && (xm != 0);
        yz = (ye == 0); yi = (ye == emax) && (ym == 0); yn = (ye == emax) && (ym != 0);
        nanv  = 8'((emax << mw) | (1 << (mw - 1)));
        infv  = 8'((sg << (ew + mw)) | (emax << mw));
        zerov = 8'(sg << (ew + mw));
        if (xn || yn) return {4'b0000, nanv};
        if ((xz && yi) || (xi && yz)) return {4'b1000, nanv};
        if (xi || yi) return {4'b0000, infv};
        if (xz || yz) return {4'b0000, zerov};
        p = (1.0 + real'(xm) / real'(1 << mw)) * (1.0 + real'(ym) / real'(1 << mw));
        e = xe + ye - 2 * bias;
        while (p >= 2.0) begin
            p = p / 2.0;
            e++;
        end
        sc  = p * real'(1 << mw);
        q   = $rtoi(sc);
        fr  = sc - real'(q);
        inx = (fr != 0.0);
        if (!r && (fr > 0.5 || (fr == 0.5 && (q % 2) == 1))) q++;
        if (q == (2 << mw)) begin
            q = q / 2;
            e++;
        end
        be = e + bias;
        if (be >= emax)
            return {4'b0101, s ? 8'((sg << (ew + mw)) | ((emax - 1) << mw) | ((1 << mw) - 1)) : infv};
        if (be <= 0) return {4'b0011, zerov};
        return {3'b000, inx, 8'((sg << (ew + mw)) | (be << mw) | (q - (1 << mw)))};
    endfunction

    task automatic run_one(input bit sel, input logic [7:0] ta, input logic [7:0] tb, input bit r,
                           input bit s, output logic [7:0] res, output logic [3:0] fl, output int lat);
        @(negedge clk);
        if (!sel) begin
            a0 = ta; b0 = tb; rm0 = r; sm0 = s; or0 = 1'b1; iv0 = 1'b1;
        end else begin
            a1 = ta; b1 = tb; rm1 = r; sm1 = s; or1 = 1'b1; iv1 = 1'b1;
        end
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        iv1 = 1'b0;
        lat = 1;
        while (!(sel ? ov1 : ov0) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = sel ? res1 : res0;
        fl  = sel ? fl1 : fl0;
    endtask

    task automatic run_stream(input int n_ops, input bit rand_ready, input int hold_cycles);
        logic [11:0] expq[$];
        logic [11:0] e;
        logic [7:0]  hold_res;
        logic [3:0]  hold_fl;
        int          sent = 0, got = 0, cyc = 0;
        bit          stalled = 0, xfer = 0;
        while (got < n_ops && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("hold_valid", ov0, 1);
                check("hold_result", res0, hold_res);
                check("hold_flags", fl0, hold_fl);
            end
            if (xfer) iv0 = 1'b0;
            xfer = 0;
            or0 = rand_ready ? 1'($urandom_range(0, 1)) : (cyc > hold_cycles);
            if (!iv0 && sent < n_ops && (!rand_ready || $urandom_range(0, 3) != 0)) begin
                a0  = 8'($urandom);
                b0  = 8'($urandom);
                rm0 = 1'($urandom);
                sm0 = 1'($urandom);
                iv0 = 1'b1;
            end
            #1;
            if (iv0 && ir0) begin
                expq.push_back(model(4, 3, a0, b0, rm0, sm0));
                sent++;
                xfer = 1;
            end
            if (ov0 && or0) begin
                check("stream_expected_present", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("stream_result", res0, e[7:0]);
                    check("stream_flags", fl0, e[11:8]);
                end
                got++;
            end
            stalled = ov0 && !or0;
            if (stalled) begin
                hold_res = res0;
                hold_fl  = fl0;
                check("in_ready_stall", ir0, 0);
            end
        end
        @(negedge clk);
        iv0 = 1'b0;
        or0 = 1'b1;
        check("stream_count", got, n_ops);
        check("stream_leftover", expq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        logic [3:0] f;
        int         lat;
        bit         seen;

        rst_n = 1'b0;
        iv0 = 0; a0 = 0; b0 = 0; rm0 = 0; sm0 = 0; or0 = 0;
        iv1 = 0; a1 = 0; b1 = 0; rm1 = 0; sm1 = 0; or1 = 1;

        vecs.push_back('{8'h38, 8'h38, 1'b0, 1'b0, 8'h38, 4'h0, 1'b0});
        vecs.push_back('{8'h3C, 8'h3C, 1'b0, 1'b0, 8'h41, 4'h0, 1'b0});
        vecs.push_back('{8'hB8, 8'h38, 1'b0, 1'b0, 8'hB8, 4'h0, 1'b0});
        vecs.push_back('{8'h39, 8'h3C, 1'b0, 1'b0, 8'h3E, 4'h1, 1'b0});
        vecs.push_back('{8'h39, 8'h3C, 1'b1, 1'b0, 8'h3D, 4'h1, 1'b0});
        vecs.push_back('{8'h39, 8'h39, 1'b0, 1'b0, 8'h3A, 4'h1, 1'b0});
        vecs.push_back('{8'h77, 8'h77, 1'b0, 1'b0, 8'h78, 4'h5, 1'b0});
        vecs.push_back('{8'h77, 8'h77, 1'b0, 1'b1, 8'h77, 4'h5, 1'b0});
        vecs.push_back('{8'h08, 8'h08, 1'b0, 1'b0, 8'h00, 4'h3, 1'b0});
        vecs.push_back('{8'h00, 8'h78, 1'b0, 1'b0, 8'h7C, 4'h8, 1'b0});
        vecs.push_back('{8'h79, 8'h38, 1'b0, 1'b0, 8'h7C, 4'h0, 1'b0});
        vecs.push_back('{8'hF8, 8'h38, 1'b0, 1'b0, 8'hF8, 4'h0, 1'b0});
        vecs.push_back('{8'h01, 8'h38, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0});
        vecs.push_back('{8'h3C, 8'h3C, 1'b0, 1'b0, 8'h3C, 4'h0, 1'b1});
        vecs.push_back('{8'h3E, 8'h3E, 1'b0, 1'b0, 8'h40, 4'h1, 1'b1});
        vecs.push_back('{8'h3E, 8'h3E, 1'b1, 1'b0, 8'h40, 4'h1, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", ov0, 0);
        check("reset_result", res0, 0);
        check("reset_flags", fl0, 0);
        check("reset_in_ready", ir0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_one(vecs[i].e5m2, vecs[i].a, vecs[i].b, vecs[i].rnd, vecs[i].sat, r, f, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_flags", i), f, vecs[i].flg);
            check($sformatf("vec%0d_latency", i), lat, 3);
        end

        run_stream(6, 1'b0, 12);
        run_stream(300, 1'b1, 0);

        // Three ops in flight, then an asynchronous reset between clock edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a0 = 8'h3C; b0 = 8'h3C; rm0 = 0; sm0 = 0; or0 = 1; iv0 = 1;
        end
        @(posedge clk);
        #2;
        iv0 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", ov0, 0);
        check("async_reset_result", res0, 0);
        check("async_reset_in_ready", ir0, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (ov0) seen = 1;
        end
        check("no_stale_after_reset", seen, 0);
        run_one(1'b0, 8'h39, 8'h39, 1'b0, 1'b0, r, f, lat);
        check("post_reset_result", r, 8'h3A);
        check("post_reset_latency", lat, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
